// File: rtl/matrix_scan_pkg.sv
// Shared types and width helpers for the row-multiplexed LED matrix scanner.
package matrix_scan_pkg;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_e;

  localparam int BRIGHT_W = 4;
  localparam logic [BRIGHT_W-1:0] BRIGHT_RST = 4'hF;

  // Width of an index/counter that must hold values 0..n-1 (never narrower than 1 bit).
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/matrix_scan_driver_scan_timer.sv
// Slot and row counters for the matrix scanner; flags the frame boundary and the
// first cycle of each frame.
module scan_timer
  import matrix_scan_pkg::*;
#(
  parameter int ROWS  = 8,
  parameter int DWELL = 1024,
  parameter int ROW_W = idx_w(ROWS),
  parameter int CNT_W = idx_w(DWELL)
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [CNT_W-1:0] cnt_o,
  output logic [ROW_W-1:0] row_o,
  output logic             boundary_o,
  output logic             frame_start_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             slot_end;

  assign slot_end = (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = slot_end ? '0 : cnt_q + CNT_W'(1);
    row_d = row_q;
    if (slot_end) begin
      row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      row_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      row_q <= row_d;
    end
  end

  assign cnt_o      = cnt_q;
  assign row_o      = row_q;
  assign boundary_o = slot_end && (row_q == ROW_LAST);
  // Held low while in reset, so the very first cycle after release still pulses.
  assign frame_start_o = rst_n && (cnt_q == '0) && (row_q == '0);

endmodule

// File: rtl/matrix_scan_driver.sv
// Tear-free row-multiplexed LED matrix scanner with shadow/active frame buffers.
// Optional macro SCREEN_SCAN_BRIGHTNESS_EN adds a 4-bit per-frame brightness input.
module matrix_scan_driver
  import matrix_scan_pkg::*;
#(
  parameter int ROWS           = 8,
  parameter int COLS           = 16,
  parameter int DWELL          = 1024,
  parameter int BLANK          = 16,
  parameter bit COL_ACTIVE_LOW = 1'b0,
  parameter bit ROW_ACTIVE_LOW = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [ROWS*COLS-1:0]     frame_data,
  input  logic                     frame_valid,
`ifdef SCREEN_SCAN_BRIGHTNESS_EN
  input  logic [BRIGHT_W-1:0]      brightness,
`endif
  output logic                     frame_ready,
  output logic [COLS-1:0]          columns,
  output logic [ROWS-1:0]          rows,
  output logic [$clog2(ROWS)-1:0]  row_idx,
  output logic                     frame_start
);

  localparam int ROW_W = $clog2(ROWS);
  localparam int CNT_W = idx_w(DWELL);

  localparam logic [COLS-1:0] COL_OFF = {COLS{COL_ACTIVE_LOW}};
  localparam logic [ROWS-1:0] ROW_OFF = {ROWS{ROW_ACTIVE_LOW}};

  logic [CNT_W-1:0]     cnt;
  logic [ROW_W-1:0]     row_cur;
  logic                 boundary;
  scan_state_e          state;

  logic [ROWS*COLS-1:0] shadow_q, shadow_d;
  logic [ROWS*COLS-1:0] active_q, active_d;
  logic                 pending_q, pending_d;
  logic                 take;

  logic [COLS-1:0]      cols_q, cols_d;
  logic [ROWS-1:0]      rows_q, rows_d;
  logic                 lit;
  logic [COLS-1:0]      row_bits [ROWS];

  scan_timer #(
    .ROWS  (ROWS),
    .DWELL (DWELL),
    .ROW_W (ROW_W),
    .CNT_W (CNT_W)
  ) u_timer (
    .clk           (clk),
    .rst_n         (rst_n),
    .cnt_o         (cnt),
    .row_o         (row_cur),
    .boundary_o    (boundary),
    .frame_start_o (frame_start)
  );

  // Frame buffers and handshake. A capture on the boundary cycle cannot also
  // swap, because the swap only looks at the registered pending flag.
  assign take        = frame_valid && !pending_q;
  assign frame_ready = !pending_q;

  always_comb begin
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    if (boundary && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
    if (take) begin
      shadow_d  = frame_data;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q  <= '0;
      active_q  <= '0;
      pending_q <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
    end
  end

  // Row 0 lives in the most significant slice of the bitmap.
  for (genvar gi = 0; gi < ROWS; gi++) begin : g_rows
    assign row_bits[gi] = active_q[(ROWS-gi)*COLS-1 -: COLS];
  end

  if (BLANK == 0) begin : g_noblank
    assign state = ST_DRIVE;
  end else begin : g_blank
    assign state = (cnt < CNT_W'(BLANK)) ? ST_BLANK : ST_DRIVE;
  end

`ifdef SCREEN_SCAN_BRIGHTNESS_EN
  localparam int ON_W = CNT_W + BRIGHT_W + 1;
  localparam logic [ON_W-1:0] SPAN = ON_W'(DWELL - BLANK);

  logic [BRIGHT_W-1:0] bright_q, bright_d;
  logic [BRIGHT_W:0]   bright_p1;
  logic [ON_W-1:0]     on_len;
  logic [ON_W-1:0]     drive_off;

  // Brightness only changes between frames so a frame never mixes two levels.
  assign bright_d  = boundary ? brightness : bright_q;
  assign bright_p1 = {1'b0, bright_q} + (BRIGHT_W+1)'(1);
  assign on_len    = (SPAN * ON_W'(bright_p1)) >> BRIGHT_W;
  assign drive_off = ON_W'(cnt) - ON_W'(BLANK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bright_q <= BRIGHT_RST;
    end else begin
      bright_q <= bright_d;
    end
  end
`endif

  always_comb begin
    lit = (state == ST_DRIVE);
`ifdef SCREEN_SCAN_BRIGHTNESS_EN
    lit = lit && (drive_off < on_len);
`endif
    rows_d = (lit ? (ROWS'(1) << row_cur) : '0) ^ ROW_OFF;
    cols_d = (lit ? row_bits[row_cur] : '0) ^ COL_OFF;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rows_q <= ROW_OFF;
      cols_q <= COL_OFF;
    end else begin
      rows_q <= rows_d;
      cols_q <= cols_d;
    end
  end

  assign rows    = rows_q;
  assign columns = cols_q;
  assign row_idx = row_cur;

endmodule

// File: tb/tb_matrix_scan_driver.sv
// Directed bench for matrix_scan_driver: one active-high and one active-low
// instance share the same stimulus; SCREEN_SCAN_BRIGHTNESS_EN enables the dimming checks.
module tb_matrix_scan_driver;

  localparam int ROWS  = 4;
  localparam int COLS  = 8;
  localparam int DWELL = 8;
  localparam int BLANK = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] frame_data = '0;
  logic        frame_valid = 1'b0;

  logic        rdy_h, rdy_l, fs_h, fs_l;
  logic [7:0]  col_h, col_l;
  logic [3:0]  row_h, row_l;
  logic [1:0]  idx_h, idx_l;
`ifdef SCREEN_SCAN_BRIGHTNESS_EN
  logic [3:0]  brightness = 4'hF;
`endif

  int total = 0;
  int bad   = 0;
  int p     = 0;
  bit after_rst = 1'b0;

  always #5 clk = ~clk;

  matrix_scan_driver #(
    .ROWS(ROWS), .COLS(COLS), .DWELL(DWELL), .BLANK(BLANK),
    .COL_ACTIVE_LOW(1'b0), .ROW_ACTIVE_LOW(1'b0)
  ) u_hi (
    .clk(clk), .rst_n(rst_n), .frame_data(frame_data), .frame_valid(frame_valid),
`ifdef SCREEN_SCAN_BRIGHTNESS_EN
    .brightness(brightness),
`endif
    .frame_ready(rdy_h), .columns(col_h), .rows(row_h), .row_idx(idx_h), .frame_start(fs_h)
  );

  matrix_scan_driver #(
    .ROWS(ROWS), .COLS(COLS), .DWELL(DWELL), .BLANK(BLANK),
    .COL_ACTIVE_LOW(1'b1), .ROW_ACTIVE_LOW(1'b1)
  ) u_lo (
    .clk(clk), .rst_n(rst_n), .frame_data(frame_data), .frame_valid(frame_valid),
`ifdef SCREEN_SCAN_BRIGHTNESS_EN
    .brightness(brightness),
`endif
    .frame_ready(rdy_l), .columns(col_l), .rows(row_l), .row_idx(idx_l), .frame_start(fs_l)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s p=%0d observed=%0h expected=%0h", tag, p, obs, exp);
    end
  endtask

  // Image shown during frame f (frame counted from the last reset release).
  function automatic logic [31:0] img_of(input int f);
    if (after_rst)   return 32'h0;
    if (f == 0)      return 32'h0;
    if (f <= 2)      return 32'hA53CFF01;
    return 32'h1E2D4B87;
  endfunction

  // Lit cycles per DRIVE window: full 6, or (6*8)>>4 = 3 once brightness 7 is in effect.
  function automatic int on_of(input int f);
`ifdef SCREEN_SCAN_BRIGHTNESS_EN
    if (!after_rst && f >= 4) return 3;
`endif
    return 6;
  endfunction

  function automatic logic ready_of(input int pp);
    if (after_rst) return 1'b1;
    if ((pp >= 6 && pp <= 31) || (pp >= 64 && pp <= 95) || pp >= 162) return 1'b0;
    return 1'b1;
  endfunction

  task automatic check_reset();
    chk("rst_ready_h", 32'(rdy_h), 32'h1);
    chk("rst_ready_l", 32'(rdy_l), 32'h1);
    chk("rst_row_idx", 32'(idx_h), 32'h0);
    chk("rst_fstart",  32'(fs_h),  32'h0);
    chk("rst_rows_h",  32'(row_h), 32'h0);
    chk("rst_cols_h",  32'(col_h), 32'h00);
    chk("rst_rows_l",  32'(row_l), 32'hF);
    chk("rst_cols_l",  32'(col_l), 32'hFF);
  endtask

  // p = clock edges since reset release; outputs reflect counter tick p-1.
  task automatic check_now();
    int q, f, r, c;
    logic [31:0] img;
    logic [7:0]  ec, ecl;
    logic [3:0]  er, erl;
    bit          lit;
    #1;
    q = p - 1;
    lit = 1'b0;
    ec = '0;
    er = '0;
    if (q >= 0) begin
      f   = q / 32;
      r   = (q / 8) % 4;
      c   = q % 8;
      img = img_of(f);
      lit = (c >= BLANK) && ((c - BLANK) < on_of(f));
      if (lit) begin
        er = 4'(1 << r);
        ec = 8'(img >> ((3 - r) * 8));
      end
    end
    ecl = ~ec;
    erl = ~er;
    chk("row_idx_h", 32'(idx_h), 32'((p / 8) % 4));
    chk("row_idx_l", 32'(idx_l), 32'((p / 8) % 4));
    chk("fstart_h",  32'(fs_h),  32'(p % 32 == 0));
    chk("fstart_l",  32'(fs_l),  32'(p % 32 == 0));
    chk("ready_h",   32'(rdy_h), 32'(ready_of(p)));
    chk("ready_l",   32'(rdy_l), 32'(ready_of(p)));
    chk("rows_h",    32'(row_h), 32'(er));
    chk("cols_h",    32'(col_h), 32'(ec));
    chk("rows_l",    32'(row_l), 32'(erl));
    chk("cols_l",    32'(col_l), 32'(ecl));
  endtask

  task automatic step();
    @(posedge clk);
    p++;
    @(negedge clk);
    check_now();
  endtask

  task automatic load(input logic [31:0] d);
    frame_data  = d;
    frame_valid = 1'b1;
    $display("offer frame p=%0d data=%h ready=%0b", p, d, rdy_h);
  endtask

  initial begin
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2 check_reset();

    @(negedge clk);
    rst_n = 1'b1;
    p = 0;
    check_now();

    for (int k = 0; k < 180; k++) begin
      frame_valid = 1'b0;
      case (k)
        5:       load(32'hA53CFF01);  // accepted, shown from frame 1
        10:      load(32'h12345678);  // offered while pending: dropped
        63:      load(32'h1E2D4B87);  // on the boundary cycle: shown from frame 3
        161:     load(32'hDEADBEEF);  // pending when reset hits: lost
        default: ;
      endcase
`ifdef SCREEN_SCAN_BRIGHTNESS_EN
      if (k == 100) brightness = 4'd7;
`endif
      step();
    end
    frame_valid = 1'b0;

    // p=180 is mid-slot of row 2; reset must act without a clock edge.
    #2 rst_n = 1'b0;
    #1 check_reset();
    $display("mid-scan reset applied p=%0d", p);

    @(negedge clk);
    rst_n = 1'b1;
    after_rst = 1'b1;
    p = 0;
    check_now();
    repeat (32) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
